// File: rtl/xif_result_queue.sv
// In-order result queue for X-IF offloaded instructions: holds execution results
// until the core commits (retire) or kills (silent drop) the matching id.
module xif_result_queue #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [ID_WIDTH-1:0]      push_id_i,
    input  logic [31:0]              push_data_i,
    input  logic [4:0]               push_rd_i,
    input  logic                     push_we_i,
    input  logic                     commit_valid_i,
    input  logic [ID_WIDTH-1:0]      commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [ID_WIDTH-1:0]      result_id_o,
    output logic [31:0]              result_data_o,
    output logic [4:0]               result_rd_o,
    output logic                     result_we_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int NID = 2 ** ID_WIDTH;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [31:0]         data_q [DEPTH];
    logic [4:0]          rd_q   [DEPTH];
    logic                we_q   [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         count_q, count_d;
    logic [NID-1:0]      committed_q, committed_d;
    logic [NID-1:0]      killed_q, killed_d;

    logic [ID_WIDTH-1:0] head_id;
    logic                head_done, drop, push, pop;

    assign head_id   = id_q[rptr_q];
    assign head_done = (count_q != '0) && committed_q[head_id];
    assign drop      = head_done && killed_q[head_id];

    assign push_ready_o   = (count_q < FULL);
    assign result_valid_o = head_done && !killed_q[head_id];
    assign result_id_o    = head_id;
    assign result_data_o  = data_q[rptr_q];
    assign result_rd_o    = rd_q[rptr_q];
    assign result_we_o    = we_q[rptr_q];
    assign count_o        = count_q;

    assign push    = push_valid_i && push_ready_o;
    assign pop     = (result_valid_o && result_ready_i) || drop;
    assign count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    // Clear of the popped id is applied before the new commit, so a commit
    // landing in the same cycle (to any id) is never lost.
    always_comb begin
        committed_d = committed_q;
        killed_d    = killed_q;
        if (pop) begin
            committed_d[head_id] = 1'b0;
            killed_d[head_id]    = 1'b0;
        end
        if (commit_valid_i) begin
            committed_d[commit_id_i] = 1'b1;
            killed_d[commit_id_i]    = commit_kill_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
                rd_q[i]   <= '0;
                we_q[i]   <= 1'b0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            if (push) begin
                id_q[wptr_q]   <= push_id_i;
                data_q[wptr_q] <= push_data_i;
                rd_q[wptr_q]   <= push_rd_i;
                we_q[wptr_q]   <= push_we_i;
                wptr_q         <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q     <= count_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
        end
    end
endmodule
